mmio_uart_tx: RTL and testbench



---
 rtl/mmio_uart_tx_pkg.sv | 27 ++
 rtl/mmio_uart_tx_fifo.sv | 47 ++++
 rtl/mmio_uart_tx.sv | 135 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, STATUS bit positions and transmitter FSM encoding for mmio_uart_tx.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_COUNT = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // Bit timer reload; a divisor of 0 is treated as 1 cycle per bit.
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO; push when full and pop when empty are ignored internally.
module tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO, bit timer and framing FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          FIFO_AW    = 4,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        int_o
);

  logic [1:0]       reg_sel;
  logic             wr, rd, push_req, pop;
  logic             full, empty;
  logic [FIFO_AW:0] count;
  logic [7:0]       fifo_dout;

  logic             ovf, ie;
  logic [15:0]      div;
  tx_state_t        state;
  logic [15:0]      timer;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;

  logic unused;
  assign unused = ^{sel_i, addr_i[31:4], addr_i[1:0], data_i[31:16]};

  assign reg_sel  = addr_i[3:2];
  assign wr       = ce_i & we_i;
  assign rd       = ce_i & ~we_i;
  assign push_req = wr & (reg_sel == REG_TXDATA);
  // Pop on the same edge the FSM loads the shift register for a new frame.
  assign pop      = ~empty & ((state == S_IDLE) | ((state == S_STOP) & (timer == 16'd0)));

  tx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (data_i[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf   <= 1'b0;
      ie    <= 1'b0;
      div   <= DIV_RESET;
      int_o <= 1'b0;
    end else begin
      if (push_req & full)                                    ovf <= 1'b1;
      else if (wr & (reg_sel == REG_STATUS) & data_i[ST_OVF]) ovf <= 1'b0;
      if (wr & (reg_sel == REG_CTRL))    ie  <= data_i[0];
      if (wr & (reg_sel == REG_BAUDDIV)) div <= data_i[15:0];
      int_o <= ie & empty & (state == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      tx_o   <= 1'b1;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          shreg <= fifo_dout;
          tx_o  <= 1'b0;
          timer <= bit_reload(div);
          state <= S_START;
        end
        S_START: if (timer == 16'd0) begin
          tx_o   <= shreg[0];
          shreg  <= shreg >> 1;
          bitcnt <= '0;
          timer  <= bit_reload(div);
          state  <= S_DATA;
        end else timer <= timer - 16'd1;
        S_DATA: if (timer == 16'd0) begin
          timer <= bit_reload(div);
          if (bitcnt == 3'd7) begin
            tx_o  <= 1'b1;
            state <= S_STOP;
          end else begin
            bitcnt <= bitcnt + 3'd1;
            tx_o   <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end else timer <= timer - 16'd1;
        S_STOP: if (timer == 16'd0) begin
          if (!empty) begin
            shreg <= fifo_dout;
            tx_o  <= 1'b0;
            timer <= bit_reload(div);
            state <= S_START;
          end else state <= S_IDLE;
        end else timer <= timer - 16'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    data_o = '0;
    if (rd) begin
      case (reg_sel)
        REG_STATUS: begin
          data_o[ST_FULL]                = full;
          data_o[ST_EMPTY]               = empty;
          data_o[ST_BUSY]                = (state != S_IDLE);
          data_o[ST_OVF]                 = ovf;
          data_o[ST_COUNT +: FIFO_AW+1]  = count;
        end
        REG_CTRL:    data_o[0]    = ie;
        REG_BAUDDIV: data_o[15:0] = div;
        default:     data_o       = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register vector table, serial-line scoreboard, framing corner cases.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, ce_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = '0, data_i = '0;
  logic [3:0]  sel_i = 4'hF;
  logic [31:0] data_o;
  logic        tx_o, int_o;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .tx_o(tx_o), .int_o(int_o)
  );

  always #5 clk = ~clk;

  int        tests = 0, fails = 0;
  logic [7:0] sb_q[$];
  int        mon_div = 4;
  bit        mon_flush = 1'b1;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // Serial-line monitor: samples mid-bit and checks decoded bytes against the scoreboard.
  bit         m_act = 1'b0;
  int         m_cnt, m_k;
  logic [7:0] m_byte;
  always @(negedge clk) begin
    if (mon_flush) m_act = 1'b0;
    else begin
      if (!m_act && tx_o === 1'b0) begin m_act = 1'b1; m_cnt = 0; end
      if (m_act) begin
        if (m_cnt % mon_div == mon_div / 2) begin
          m_k = m_cnt / mon_div;
          if (m_k == 0) check("mon_start", {31'd0, tx_o}, 32'd0);
          else if (m_k <= 8) m_byte[m_k-1] = tx_o;
          else begin
            check("mon_stop", {31'd0, tx_o}, 32'd1);
            if (sb_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL mon_frame: got unexpected byte 0x%02h expected none", m_byte);
            end else check("mon_byte", {24'd0, m_byte}, {24'd0, sb_q.pop_front()});
            m_act = 1'b0;
          end
        end
        m_cnt++;
      end
    end
  end

  // Bus tasks are entered at a negedge; wr leaves at the next negedge.
  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b1; addr_i = {28'd0, r, 2'b00}; data_i = d;
    @(negedge clk);
    ce_i = 1'b0; we_i = 1'b0; data_i = '0;
  endtask

  task automatic rd(input logic [1:0] r, output logic [31:0] d);
    ce_i = 1'b1; we_i = 1'b0; addr_i = {28'd0, r, 2'b00};
    #1 d = data_o;
    ce_i = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic wait_idle(input string n);
    logic [31:0] st;
    bit ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      rd(REG_STATUS, st);
      if (st == 32'h2) ok = 1'b1;
    end
    check(n, {31'd0, ok}, 32'd1);
  endtask

  // Push one byte into an idle transmitter and check the waveform cycle by cycle.
  task automatic send_check(input logic [7:0] b, input int div, input string n);
    logic [31:0] st;
    int errs = 0, busy_n = 0;
    sb_q.push_back(b);
    wr(REG_TXDATA, {24'd0, b});
    for (int i = 0; i <= 10 * div; i++) begin
      @(negedge clk);
      rd(REG_STATUS, st);
      if (tx_o !== ((i < 10 * div) ? frame_bit(b, i / div) : 1'b1)) errs++;
      if (st[ST_BUSY]) busy_n++;
    end
    check({n, "_wave"}, errs, 0);
    check({n, "_busy"}, busy_n, 10 * div);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  r;
    logic [31:0] wd;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] st;
    int errs, n;

    vecs[0]  = '{1'b0, REG_STATUS,  32'h0,         32'h0000_0002, "rst_status"};
    vecs[1]  = '{1'b0, REG_BAUDDIV, 32'h0,         32'h0000_01B2, "rst_bauddiv"};
    vecs[2]  = '{1'b0, REG_CTRL,    32'h0,         32'h0000_0000, "rst_ctrl"};
    vecs[3]  = '{1'b0, REG_TXDATA,  32'h0,         32'h0000_0000, "txdata_read0"};
    vecs[4]  = '{1'b1, REG_CTRL,    32'hFFFF_FFFF, 32'h0,         "wr_ctrl"};
    vecs[5]  = '{1'b0, REG_CTRL,    32'h0,         32'h0000_0001, "ctrl_ie_only"};
    vecs[6]  = '{1'b1, REG_CTRL,    32'h0,         32'h0,         "wr_ctrl0"};
    vecs[7]  = '{1'b0, REG_CTRL,    32'h0,         32'h0000_0000, "ctrl_clear"};
    vecs[8]  = '{1'b1, REG_BAUDDIV, 32'hABCD_0007, 32'h0,         "wr_baud7"};
    vecs[9]  = '{1'b0, REG_BAUDDIV, 32'h0,         32'h0000_0007, "baud_low16"};
    vecs[10] = '{1'b1, REG_BAUDDIV, 32'h0000_0004, 32'h0,         "wr_baud4"};
    vecs[11] = '{1'b0, REG_BAUDDIV, 32'h0,         32'h0000_0004, "baud_4"};
    vecs[12] = '{1'b1, REG_STATUS,  32'hFFFF_FFF7, 32'h0,         "wr_status"};
    vecs[13] = '{1'b0, REG_STATUS,  32'h0,         32'h0000_0002, "status_wr_ignored"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    mon_flush = 1'b0;

    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_int", {31'd0, int_o}, 32'd0);
    check("idle_data_o", data_o, 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].we) wr(vecs[i].r, vecs[i].wd);
      else begin
        rd(vecs[i].r, st);
        check(vecs[i].name, st, vecs[i].exp);
        @(negedge clk);
      end
    end

    // Single frame at 4 cycles per bit.
    send_check(8'h55, 4, "frame55");

    // Back-to-back frames: stop bit of the first runs straight into the second start bit.
    sb_q.push_back(8'hA5);
    sb_q.push_back(8'h3C);
    wr(REG_TXDATA, 32'hA5);
    wr(REG_TXDATA, 32'h3C);
    errs = 0;
    for (int i = 0; i <= 80; i++) begin
      if (i > 0) @(negedge clk);
      if (tx_o !== ((i < 40) ? frame_bit(8'hA5, i / 4) :
                    (i < 80) ? frame_bit(8'h3C, (i - 40) / 4) : 1'b1)) errs++;
    end
    check("b2b_wave", errs, 0);
    rd(REG_STATUS, st);
    check("b2b_idle", st, 32'h2);

    // Overflow: one byte in flight, then 17 pushes into a 16-entry FIFO.
    @(negedge clk);
    sb_q.push_back(8'h11);
    wr(REG_TXDATA, 32'h11);
    @(negedge clk);
    for (int j = 0; j < 17; j++) begin
      if (j < 16) sb_q.push_back(8'h20 + 8'(j));
      wr(REG_TXDATA, 32'h20 + j);
    end
    rd(REG_STATUS, st);
    check("ovf_status", st, 32'h0000_100D);
    @(negedge clk);
    wr(REG_STATUS, 32'h8);
    rd(REG_STATUS, st);
    check("ovf_w1c", st, 32'h0000_1005);
    wait_idle("ovf_drain");
    check("ovf_sb_empty", sb_q.size(), 0);

    // Divisor 0 runs at one cycle per bit.
    @(negedge clk);
    wr(REG_BAUDDIV, 32'h0);
    mon_div = 1;
    send_check(8'h81, 1, "div0");
    @(negedge clk);
    wr(REG_BAUDDIV, 32'h4);
    mon_div = 4;

    // Interrupt on drain.
    wr(REG_CTRL, 32'h1);
    @(negedge clk);
    check("int_idle", {31'd0, int_o}, 32'd1);
    sb_q.push_back(8'h0F);
    wr(REG_TXDATA, 32'h0F);
    check("int_push_edge", {31'd0, int_o}, 32'd1);
    @(negedge clk);
    check("int_drop", {31'd0, int_o}, 32'd0);
    n = 0;
    while (int_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("int_rise_cycle", n, 41);
    sb_q.push_back(8'hF0);
    wr(REG_TXDATA, 32'hF0);
    @(negedge clk);
    check("int_push_clear", {31'd0, int_o}, 32'd0);
    wait_idle("int_drain");
    @(negedge clk);
    check("int_redrain", {31'd0, int_o}, 32'd1);
    wr(REG_CTRL, 32'h0);
    check("int_ie_clear_lag", {31'd0, int_o}, 32'd1);
    @(negedge clk);
    check("int_ie_clear", {31'd0, int_o}, 32'd0);

    // Reset in the middle of the data bits.
    sb_q.push_back(8'hC3);
    wr(REG_TXDATA, 32'hC3);
    repeat (15) @(negedge clk);
    check("pre_rst_busy", {31'd0, tx_o === 1'b1 || tx_o === 1'b0}, 32'd1);
    mon_flush = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, tx_o}, 32'd1);
    rst = 1'b0;
    sb_q.delete();
    rd(REG_STATUS, st);
    check("rst_mid_status", st, 32'h2);
    rd(REG_BAUDDIV, st);
    check("rst_mid_baud", st, 32'h1B2);
    check("rst_mid_int", {31'd0, int_o}, 32'd0);
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1) errs++;
    end
    check("rst_quiet", errs, 0);
    mon_flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
